// File: rtl/acc_pkg.sv
// ---------------------------------------------------------------------------
// acc_pkg
// Shared constants and helpers for the accelerator cluster interconnect.
//   AccIdBaseWidth : width of the requester-local transaction ID.
//   idx_width()    : bits needed to index NumReq requesters (minimum 1).
//   ext_id_width() : extended ID width = base ID + requester index bits.
// ---------------------------------------------------------------------------
package acc_pkg;

    localparam int AccIdBaseWidth = 5;

    function automatic int idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int ext_id_width(input int num_req);
        return AccIdBaseWidth + idx_width(num_req);
    endfunction

endpackage

// File: rtl/acc_id_fifo.sv
// ---------------------------------------------------------------------------
// acc_id_fifo
// Synchronous ID FIFO, used to track outstanding transaction IDs.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset (clears pointers/count)
//   push_i, data_i : write one entry (ignored when full)
//   pop_i          : drop the head entry (ignored when empty)
//   head_o         : oldest entry
//   count_o        : number of stored entries, 0..Depth
//   full_o/empty_o : derived from count_o
// Depth must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module acc_id_fifo #(
    parameter int Width = 6,
    parameter int Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         head_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  count;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == CntW'(Depth));
    assign empty_o = (count == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem[rd_ptr];
    assign count_o = count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push != do_pop)
                count <= do_push ? count + 1'b1 : count - 1'b1;
        end
    end

    // Storage holds data only; validity is tracked by count.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/acc_slv_adapter.sv
// ---------------------------------------------------------------------------
// acc_slv_adapter
// Responder-side adapter between the interconnect (extended-ID request/
// response pair) and a single in-order accelerator. Requests pass straight
// through to the accelerator while their IDs are queued; each result is
// tagged with the oldest queued ID and held in a one-entry response register.
// Ports:
//   clk_i, rst_i                       : clock, synchronous active-high reset
//   q_valid_i/q_ready_o/q_id_i/q_op_i/q_arg_i : request channel
//   p_valid_o/p_ready_i/p_id_o/p_data_o/p_error_o : response channel
//   acc_valid_o/acc_ready_i/acc_op_o/acc_arg_o   : accelerator issue
//   acc_res_valid_i/acc_res_ready_o/acc_res_data_i/acc_res_error_i : result
//   busy_o                             : outstanding IDs or a pending response
// Optional build macro ACC_SLV_ADAPTER_TIMEOUT_EN adds a watchdog that
// answers a stuck head ID with an error response after TimeoutCycles.
// ---------------------------------------------------------------------------
module acc_slv_adapter
    import acc_pkg::*;
#(
    parameter int DataWidth      = 32,
    parameter int ExtIdWidth     = ext_id_width(2),
    parameter int MaxOutstanding = 4,
    parameter int TimeoutCycles  = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   q_valid_i,
    output logic                   q_ready_o,
    input  logic [ExtIdWidth-1:0]  q_id_i,
    input  logic [31:0]            q_op_i,
    input  logic [3*DataWidth-1:0] q_arg_i,
    output logic                   p_valid_o,
    input  logic                   p_ready_i,
    output logic [ExtIdWidth-1:0]  p_id_o,
    output logic [DataWidth-1:0]   p_data_o,
    output logic                   p_error_o,
    output logic                   acc_valid_o,
    input  logic                   acc_ready_i,
    output logic [31:0]            acc_op_o,
    output logic [3*DataWidth-1:0] acc_arg_o,
    input  logic                   acc_res_valid_i,
    output logic                   acc_res_ready_o,
    input  logic [DataWidth-1:0]   acc_res_data_i,
    input  logic                   acc_res_error_i,
    output logic                   busy_o
);

    localparam int CntW = $clog2(MaxOutstanding) + 1;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ExtIdWidth-1:0] fifo_head;
    logic [CntW-1:0]       fifo_count;
    logic                  issue_fire;
    logic                  res_fire;
    logic                  timeout_fire;
    logic                  pop;
    logic                  out_free;
    logic                  p_valid_next;
    logic [CntW-1:0]       cnt_next;
    logic                  busy_q;

    // Issue path: the accelerator only sees a request the FIFO can record.
    // A pop in the same cycle does not free a full FIFO for issue.
    assign q_ready_o   = acc_ready_i && !fifo_full;
    assign acc_valid_o = q_valid_i && !fifo_full;
    assign acc_op_o    = q_op_i;
    assign acc_arg_o   = q_arg_i;
    assign issue_fire  = q_valid_i && q_ready_o;

    // Response path: accept a result only when the output register is free
    // or draining, and never while no ID is outstanding.
    assign out_free        = !p_valid_o || p_ready_i;
    assign acc_res_ready_o = out_free && !fifo_empty;
    assign res_fire        = acc_res_valid_i && acc_res_ready_o;
    assign pop             = res_fire || timeout_fire;

    acc_id_fifo #(
        .Width (ExtIdWidth),
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (issue_fire),
        .data_i  (q_id_i),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef ACC_SLV_ADAPTER_TIMEOUT_EN
    localparam int WdW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    localparam logic [WdW-1:0] WdLast = WdW'(TimeoutCycles - 1);

    logic [WdW-1:0] wd_cnt;

    // Watchdog ages the head ID; it saturates at the limit so a timeout
    // blocked by a held response fires as soon as the register frees up.
    always_ff @(posedge clk_i) begin
        if (rst_i || fifo_empty || pop) begin
            wd_cnt <= '0;
        end else if (wd_cnt != WdLast) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // A real result in the same cycle takes priority over the timeout.
    assign timeout_fire = (wd_cnt == WdLast) && !fifo_empty && out_free && !res_fire;
`else
    assign timeout_fire = 1'b0;
`endif

    assign p_valid_next = pop || (p_valid_o && !p_ready_i);
    assign cnt_next     = fifo_count + CntW'(issue_fire) - CntW'(pop);

    // Response register: p_* only change on a load, so a held response
    // stays stable until p_ready_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_valid_o <= 1'b0;
            p_id_o    <= '0;
            p_data_o  <= '0;
            p_error_o <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            p_valid_o <= p_valid_next;
            busy_q    <= (cnt_next != '0) || p_valid_next;
            if (res_fire) begin
                p_id_o    <= fifo_head;
                p_data_o  <= acc_res_data_i;
                p_error_o <= acc_res_error_i;
            end else if (timeout_fire) begin
                p_id_o    <= fifo_head;
                p_data_o  <= '0;
                p_error_o <= 1'b1;
            end
        end
    end

    assign busy_o = busy_q;

    // A result with no outstanding ID means the accelerator broke protocol.
    a_no_result_when_empty: assert property (
        @(posedge clk_i) disable iff (rst_i) !(acc_res_valid_i && fifo_empty));

    // Parameter legality.
    a_depth_pow2: assert property (@(posedge clk_i)
        (MaxOutstanding >= 2) && ((MaxOutstanding & (MaxOutstanding - 1)) == 0));
    a_timeout_min: assert property (@(posedge clk_i) TimeoutCycles >= 2);

endmodule

// File: tb/tb_acc_slv_adapter.sv
// ---------------------------------------------------------------------------
// tb_acc_slv_adapter
// Directed and random stimulus for acc_slv_adapter, checked against a
// queue-based reference model of outstanding IDs and the response register.
// ---------------------------------------------------------------------------
module tb_acc_slv_adapter;

    localparam int MAXO = 4;
`ifdef ACC_SLV_ADAPTER_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        q_valid_i;
    logic        q_ready_o;
    logic [5:0]  q_id_i;
    logic [31:0] q_op_i;
    logic [95:0] q_arg_i;
    logic        p_valid_o;
    logic        p_ready_i;
    logic [5:0]  p_id_o;
    logic [31:0] p_data_o;
    logic        p_error_o;
    logic        acc_valid_o;
    logic        acc_ready_i;
    logic [31:0] acc_op_o;
    logic [95:0] acc_arg_o;
    logic        acc_res_valid_i;
    logic        acc_res_ready_o;
    logic [31:0] acc_res_data_i;
    logic        acc_res_error_i;
    logic        busy_o;

    acc_slv_adapter #(
        .DataWidth      (32),
        .ExtIdWidth     (6),
        .MaxOutstanding (MAXO),
        .TimeoutCycles  (TO)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .q_valid_i       (q_valid_i),
        .q_ready_o       (q_ready_o),
        .q_id_i          (q_id_i),
        .q_op_i          (q_op_i),
        .q_arg_i         (q_arg_i),
        .p_valid_o       (p_valid_o),
        .p_ready_i       (p_ready_i),
        .p_id_o          (p_id_o),
        .p_data_o        (p_data_o),
        .p_error_o       (p_error_o),
        .acc_valid_o     (acc_valid_o),
        .acc_ready_i     (acc_ready_i),
        .acc_op_o        (acc_op_o),
        .acc_arg_o       (acc_arg_o),
        .acc_res_valid_i (acc_res_valid_i),
        .acc_res_ready_o (acc_res_ready_o),
        .acc_res_data_i  (acc_res_data_i),
        .acc_res_error_i (acc_res_error_i),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: IDs awaiting a result, and the response register.
    logic [5:0]  m_idq[$];
    logic        m_pv;
    logic [5:0]  m_pid;
    logic [31:0] m_pdata;
    logic        m_perr;
    logic [5:0]  got_ids[$];

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic zero_inputs();
        q_valid_i       = 1'b0;
        q_id_i          = '0;
        q_op_i          = '0;
        q_arg_i         = '0;
        p_ready_i       = 1'b0;
        acc_ready_i     = 1'b0;
        acc_res_valid_i = 1'b0;
        acc_res_data_i  = '0;
        acc_res_error_i = 1'b0;
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic do_reset();
        rst_i = 1'b1;
        zero_inputs();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        m_idq.delete();
        got_ids.delete();
        m_pv = 1'b0;
    endtask

    // One clock of stimulus with full output checking against the model.
    task automatic cycle(input logic qv, input logic [5:0] qid, input logic accr,
                         input logic rv, input logic [31:0] rd, input logic re,
                         input logic pr);
        logic iss;
        logic res;
        logic room;
        q_valid_i       = qv;
        q_id_i          = qid;
        acc_ready_i     = accr;
        acc_res_valid_i = rv && (m_idq.size() != 0);
        acc_res_data_i  = rd;
        acc_res_error_i = re;
        p_ready_i       = pr;
        q_op_i          = $urandom;
        q_arg_i         = {$urandom, $urandom, $urandom};
        #1;
        room = (m_idq.size() < MAXO);
        iss  = qv && accr && room;
        res  = acc_res_valid_i && (!m_pv || pr);
        chk("q_ready",   q_ready_o,       accr && room);
        chk("acc_valid", acc_valid_o,     qv && room);
        chk("res_ready", acc_res_ready_o, (!m_pv || pr) && (m_idq.size() != 0));
        chk("acc_op",    acc_op_o,        q_op_i);
        chk("acc_arg",   acc_arg_o,       q_arg_i);
        chk("p_valid",   p_valid_o,       m_pv);
        chk("busy",      busy_o,          (m_idq.size() != 0) || m_pv);
        if (m_pv) begin
            chk("p_id",    p_id_o,    m_pid);
            chk("p_data",  p_data_o,  m_pdata);
            chk("p_error", p_error_o, m_perr);
            if (pr) got_ids.push_back(p_id_o);
        end
        @(posedge clk_i); #1;
        if (m_pv && pr) m_pv = 1'b0;
        if (res) begin
            m_pv    = 1'b1;
            m_pid   = m_idq.pop_front();
            m_pdata = rd;
            m_perr  = re;
        end
        if (iss) m_idq.push_back(qid);
    endtask

    task automatic idle(input logic pr);
        cycle(1'b0, 6'd0, 1'b0, 1'b0, 32'd0, 1'b0, pr);
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * MAXO; i++) begin
            if (m_idq.size() != 0 || m_pv)
                cycle(1'b0, 6'd0, 1'b0, 1'b1, $urandom, 1'($urandom), 1'b1);
        end
        chk("drained", busy_o, 1'b0);
    endtask

    initial begin
        rst_i = 1'b1;
        zero_inputs();
        m_pv = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        // Reset state
        chk("rst_p_valid",   p_valid_o,   1'b0);
        chk("rst_acc_valid", acc_valid_o, 1'b0);
        chk("rst_busy",      busy_o,      1'b0);
        chk("rst_p_id",      p_id_o,      6'd0);
        chk("rst_p_data",    p_data_o,    32'd0);
        chk("rst_p_error",   p_error_o,   1'b0);
        rst_i = 1'b0;

        // Single op: result three cycles after issue
        cycle(1'b1, 6'h25, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        cycle(1'b0, 6'd0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        chk("single_valid", p_valid_o, 1'b1);
        chk("single_id",    p_id_o,    6'h25);
        chk("single_data",  p_data_o,  32'hDEAD_BEEF);
        chk("single_err",   p_error_o, 1'b0);
        idle(1'b1);

        // Full: four issues, fifth blocked, pop does not bypass, then issues
        for (int i = 0; i < MAXO; i++)
            cycle(1'b1, 6'(i + 10), 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 6'd20, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 6'd20, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b1);
        cycle(1'b1, 6'd20, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        drain();

        // Ordering: three IDs, back-to-back results
        cycle(1'b1, 6'd3,  1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 6'd17, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 6'd40, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        got_ids.delete();
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 6'd0, 1'b0, 1'b1, 32'(100 + i), 1'b0, 1'b1);
        idle(1'b1);
        chk("order_n", 96'(got_ids.size()), 96'd3);
        if (got_ids.size() == 3) begin
            chk("order_0", got_ids[0], 6'd3);
            chk("order_1", got_ids[1], 6'd17);
            chk("order_2", got_ids[2], 6'd40);
        end

        // Backpressure: two results pending, response held for five cycles
        cycle(1'b1, 6'd7, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle(1'b1, 6'd8, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        got_ids.delete();
        cycle(1'b0, 6'd0, 1'b0, 1'b1, 32'hAAAA_0001, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 6'd0, 1'b0, 1'b1, 32'hAAAA_0002, 1'b0, 1'b0);
        chk("bp_hold_id", p_id_o, 6'd7);
        drain();
        chk("bp_order_n", 96'(got_ids.size()), 96'd2);
        if (got_ids.size() == 2) begin
            chk("bp_order_0", got_ids[0], 6'd7);
            chk("bp_order_1", got_ids[1], 6'd8);
        end

        // Simultaneous push and pop at count 2 keeps count at 2
        cycle(1'b1, 6'd1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 6'd2, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 6'd3, 1'b1, 1'b1, 32'h5, 1'b0, 1'b1);
        cycle(1'b1, 6'd4, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle(1'b1, 6'd5, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("simul_full", q_ready_o, 1'b0);
        drain();

        // Reset with three outstanding
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 6'(i + 30), 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        do_reset();
        chk("mid_rst_busy",   busy_o,    1'b0);
        chk("mid_rst_pvalid", p_valid_o, 1'b0);
        idle(1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom), 6'($urandom), ($urandom % 4) != 0,
                  ($urandom % 4) != 0, $urandom, 1'($urandom), ($urandom % 4) != 0);
        drain();

`ifdef ACC_SLV_ADAPTER_TIMEOUT_EN
        // Timeout: ID 9 never answered
        begin
            int n;
            logic seen;
            do_reset();
            cycle(1'b1, 6'd9, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
            zero_inputs();
            n = 0;
            seen = 1'b0;
            for (int i = 1; i <= 3 * TO && !seen; i++) begin
                @(posedge clk_i); #1;
                n = i;
                seen = p_valid_o;
            end
            chk("to_seen",   seen,            1'b1);
            chk("to_cycles", 96'(n),          96'(TO));
            chk("to_id",     p_id_o,          6'd9);
            chk("to_data",   p_data_o,        32'd0);
            chk("to_err",    p_error_o,       1'b1);
            chk("to_empty",  acc_res_ready_o, 1'b0);
            p_ready_i = 1'b1;
            @(posedge clk_i); #1;
            chk("to_busy",   busy_o,          1'b0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
